cpu_trace_monitor: RTL and testbench
====================================

# cpu_trace_monitor

Synthesizable retirement-trace monitor for the sequential RISC-V core. It sits beside `cpu_sequential` and watches its retire-side signals: PC, instruction, register writeback, memory write and branch outcome. Each retired instruction is captured into a parametrised trace FIFO drained over a valid/ready port. It also counts cycles and retired instructions, detects the halt instruction (all-zero word), and applies a watchdog, so simulation and FPGA runs get a halt/timeout verdict and an instruction trace without hierarchical peeking.

## Interface
Parameters:
- `XLEN`, 64: datapath width (PC, register data, memory address/data, counters).
- `DEPTH`, 16: trace FIFO entries; power of two, ≥2.
- `HALT_INSN`, 32'h0000_0000: instruction word that signals halt.
- `WDOG_CYCLES`, 0: watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- `clk`  in  1  — single clock; all state on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `retire_valid`  in  1  — one instruction retires this cycle.
- `retire_pc`  in  XLEN  — PC of the retiring instruction.
- `retire_insn`  in  32  — instruction word.
- `retire_rd_we`  in  1  — register write enable.
- `retire_rd`  in  5  — destination register.
- `retire_rd_data`  in  XLEN  — writeback data.
- `retire_mem_we`  in  1  — data-memory write.
- `retire_mem_addr`  in  XLEN  — store address.
- `retire_mem_data`  in  XLEN  — store data.
- `retire_br_taken`  in  1  — branch taken.
- `clear`  in  1  — synchronous restart: counters zeroed, FIFO flushed, state set to RUN.
- `trace_valid`  out  1  — the head entry is valid.
- `trace_ready`  in  1  — the consumer accepts the head entry.
- `trace_entry`  out  `trace_entry_t`  — head entry (see Structure).
- `cycle_cnt`  out  XLEN  — cycles spent in RUN.
- `retire_cnt`  out  XLEN  — instructions retired in RUN (halt word excluded).
- `drop_cnt`  out  16  — entries dropped because the FIFO was full; saturates at 16'hFFFF.
- `overflow`  out  1  — sticky; set on the first drop.
- `halted`  out  1  — state is DONE and the halt word caused it.
- `timeout`  out  1  — sticky; set when the watchdog fired.

## Operation
- FSM states: RUN, DRAIN, DONE. Reset state is RUN.
- RUN:
  - Each cycle, `cycle_cnt` increments.
  - When `retire_valid` is high and `retire_insn` ≠ HALT_INSN, an entry is pushed and `retire_cnt` increments.
  - When `retire_valid` is high and `retire_insn` == HALT_INSN, nothing is pushed and the FSM goes to DRAIN.
  - When WDOG_CYCLES ≠ 0 and `cycle_cnt` == WDOG_CYCLES−1 at a clock edge, `timeout` is set and the FSM goes to DRAIN. If a halt occurs in the same cycle, `timeout` is still set and `halted` is also reported.
- DRAIN: pushes and counters are frozen; the FIFO keeps draining. When the FIFO is empty, the FSM goes to DONE.
- DONE: everything is frozen until `clear` or reset.
- FIFO push when full:
  - If a pop happens in the same cycle (`trace_valid && trace_ready`), the push is accepted.
  - Otherwise the entry is dropped, `drop_cnt` increments (saturating), and `overflow` is set.
- Counters wrap modulo 2^XLEN; `drop_cnt` saturates.
- `clear` takes precedence over every other event in its cycle.
- Reset mid-run: everything returns to reset values immediately; in-flight entries are lost.
- Reset values: `trace_valid`=0, `trace_entry`=0, all counters 0, `overflow`=0, `halted`=0, `timeout`=0.

## Timing
- Capture latency: a push at edge N makes the entry visible at the head with `trace_valid`=1 after edge N (FIFO was empty); no bypass.
- Throughput: one push and one pop per cycle.
- `trace_entry` is stable while `trace_valid` is high and `trace_ready` is low.
- Halt word retired at edge N: state is DRAIN after edge N. With the FIFO empty, state is DONE and `halted`=1 after edge N+1.
- `clear` asserted at edge N: all state takes its reset values after edge N.

## Configuration
- `TRACE_MEM_EN` defined: entries carry `mem_we`, `mem_addr`, `mem_data`.
- `TRACE_MEM_EN` undefined:
  - These fields do not exist in `trace_entry_t`, and the memory inputs are left unused.
  - Entry width drops by 2·XLEN+1; all other behaviour is identical.

## Structure
- Package `trace_pkg`:
  - `trace_entry_t` packed struct: `pc`, `insn`, `rd_we`, `rd`, `rd_data`, `br_taken`, plus the memory fields under `TRACE_MEM_EN`.
  - `mon_state_e` enum.
  - `DEFAULT_HALT_INSN` constant.
- Sub-module `trace_fifo`: parametrised by DEPTH and entry type; registered head; full/empty via pointers with a wrap bit.
- The FSM and counters live in the top module.

## Test plan
- Program of 5 `addi` followed by the halt word, `trace_ready`=1:
  - 5 entries come out in order, with PCs 0x0, 0x4, …, 0x10.
  - `retire_cnt`=5, `halted`=1, `timeout`=0.
- DEPTH=4, `trace_ready`=0, 6 retires:
  - FIFO holds the first 4 entries; `drop_cnt`=2, `overflow`=1.
  - Then raise `trace_ready`: 4 entries drain with PC order preserved.
- FIFO full, push and pop in the same cycle: no drop, FIFO stays at count 4, head advances by one entry.
- WDOG_CYCLES=20, infinite loop (`beq x0,x0,0`): `timeout`=1 and DONE after 20 RUN cycles; `cycle_cnt`=20; `halted`=0.
- `reset_n` pulsed low mid-run with 3 entries queued: all outputs return to reset values asynchronously; the next retire is entry 0 with `retire_cnt`=1.
- `clear` in DONE, then rerun: counters restart from 0 and `halted` deasserts one cycle after `clear`. Build with and without `TRACE_MEM_EN`: `sd` entry carries `mem_addr`/`mem_data` only when the macro is defined.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the retirement-trace monitor.
// Optional build macro: TRACE_MEM_EN adds store fields to each trace entry.
package trace_pkg;

  // Entry fields use this width, so the monitor's XLEN should match it.
  localparam int TRACE_XLEN = 64;

  localparam logic [31:0] DEFAULT_HALT_INSN = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           insn;
    logic                  rd_we;
    logic [4:0]            rd;
    logic [TRACE_XLEN-1:0] rd_data;
    logic                  br_taken;
`ifdef TRACE_MEM_EN
    logic                  mem_we;
    logic [TRACE_XLEN-1:0] mem_addr;
    logic [TRACE_XLEN-1:0] mem_data;
`endif
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Trace FIFO with a registered head entry; full/empty from wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int  DEPTH   = 16,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop_ready,
  output logic   valid,
  output entry_t head,
  output logic   full
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_nxt;
  logic [AW:0]   rd_ptr_nxt;
  logic          pop;
  logic          push_ok;
  entry_t        head_nxt;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = valid && pop_ready;
  assign push_ok = push && (!full || pop);

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

  // Next head: the slot the read pointer will point at; if that slot is being
  // written this same cycle (empty or single-entry FIFO), forward the new data.
  always_comb begin
    head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
      head_nxt = push_data;
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointers and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      head   <= head_nxt;
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Retirement-trace monitor: captures retired instructions into a trace FIFO,
// counts RUN cycles and retirements, detects the halt word and applies an
// optional watchdog. Optional build macro: TRACE_MEM_EN (store fields in entries).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | capturing retirements, counters running
// ST_DRAIN | halt or watchdog seen; capture frozen, FIFO still draining
// ST_DONE  | FIFO empty after stop; everything frozen until clear/reset
module cpu_trace_monitor
  import trace_pkg::*;
#(
  parameter int          XLEN        = TRACE_XLEN,
  parameter int          DEPTH       = 16,
  parameter logic [31:0] HALT_INSN   = DEFAULT_HALT_INSN,
  parameter int          WDOG_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] retire_pc,
  input  logic [31:0]     retire_insn,
  input  logic            retire_rd_we,
  input  logic [4:0]      retire_rd,
  input  logic [XLEN-1:0] retire_rd_data,
  input  logic            retire_mem_we,
  input  logic [XLEN-1:0] retire_mem_addr,
  input  logic [XLEN-1:0] retire_mem_data,
  input  logic            retire_br_taken,
  input  logic            clear,
  output logic            trace_valid,
  input  logic            trace_ready,
  output trace_entry_t    trace_entry,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] retire_cnt,
  output logic [15:0]     drop_cnt,
  output logic            overflow,
  output logic            halted,
  output logic            timeout
);

  mon_state_e   state;
  logic         halt_seen;
  logic         is_halt;
  logic         wdog_hit;
  logic         push;
  logic         pop;
  logic         drop;
  logic         fifo_full;
  trace_entry_t entry_in;

  assign is_halt  = retire_valid && (retire_insn == HALT_INSN);
  assign wdog_hit = (WDOG_CYCLES != 0) && (cycle_cnt == XLEN'(WDOG_CYCLES - 1));
  assign push     = (state == ST_RUN) && retire_valid && !is_halt && !clear;
  assign pop      = trace_valid && trace_ready;
  assign drop     = push && fifo_full && !pop;

  // Pack the retire-side signals into a trace entry.
  always_comb begin
    entry_in          = '0;
    entry_in.pc       = TRACE_XLEN'(retire_pc);
    entry_in.insn     = retire_insn;
    entry_in.rd_we    = retire_rd_we;
    entry_in.rd       = retire_rd;
    entry_in.rd_data  = TRACE_XLEN'(retire_rd_data);
    entry_in.br_taken = retire_br_taken;
`ifdef TRACE_MEM_EN
    entry_in.mem_we   = retire_mem_we;
    entry_in.mem_addr = TRACE_XLEN'(retire_mem_addr);
    entry_in.mem_data = TRACE_XLEN'(retire_mem_data);
`endif
  end

`ifndef TRACE_MEM_EN
  logic unused_mem;
  assign unused_mem = ^{retire_mem_we, retire_mem_addr, retire_mem_data};
`endif

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (trace_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush     (clear),
    .push      (push),
    .push_data (entry_in),
    .pop_ready (trace_ready),
    .valid     (trace_valid),
    .head      (trace_entry),
    .full      (fifo_full)
  );

  // Monitor FSM, counters and sticky verdict flags; clear beats everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      halt_seen  <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
    end else if (clear) begin
      state      <= ST_RUN;
      halt_seen  <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          cycle_cnt <= cycle_cnt + XLEN'(1);
          if (push)
            retire_cnt <= retire_cnt + XLEN'(1);
          if (drop) begin
            if (drop_cnt != 16'hFFFF)
              drop_cnt <= drop_cnt + 16'd1;
            overflow <= 1'b1;
          end
          if (is_halt || wdog_hit) begin
            state     <= ST_DRAIN;
            halt_seen <= is_halt;
            timeout   <= wdog_hit;
          end
        end
        ST_DRAIN: begin
          if (!trace_valid) begin
            state  <= ST_DONE;
            halted <= halt_seen;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: a table-driven program, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_cpu_trace_monitor;
  import trace_pkg::*;

  localparam logic [31:0] ADDI = 32'h0010_8093;
  localparam logic [31:0] BEQ0 = 32'h0000_0063;
  localparam logic [31:0] SD   = 32'h00B5_3023;
  localparam int          A_DEPTH = 4;

  logic         clk;
  logic         reset_n;
  logic         retire_valid;
  logic [63:0]  retire_pc;
  logic [31:0]  retire_insn;
  logic         retire_rd_we;
  logic [4:0]   retire_rd;
  logic [63:0]  retire_rd_data;
  logic         retire_mem_we;
  logic [63:0]  retire_mem_addr;
  logic [63:0]  retire_mem_data;
  logic         retire_br_taken;
  logic         clear;
  logic         trace_ready;

  logic         a_valid, a_ovf, a_halted, a_timeout;
  trace_entry_t a_entry;
  logic [63:0]  a_cycle, a_retire;
  logic [15:0]  a_drop;

  logic         w_valid, w_ovf, w_halted, w_timeout;
  trace_entry_t w_entry;
  logic [63:0]  w_cycle, w_retire;
  logic [15:0]  w_drop;

  int checks = 0;
  int errors = 0;

  cpu_trace_monitor #(.XLEN(64), .DEPTH(A_DEPTH), .HALT_INSN(32'h0), .WDOG_CYCLES(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_insn(retire_insn), .retire_rd_we(retire_rd_we), .retire_rd(retire_rd),
    .retire_rd_data(retire_rd_data), .retire_mem_we(retire_mem_we),
    .retire_mem_addr(retire_mem_addr), .retire_mem_data(retire_mem_data),
    .retire_br_taken(retire_br_taken), .clear(clear), .trace_valid(a_valid),
    .trace_ready(trace_ready), .trace_entry(a_entry), .cycle_cnt(a_cycle),
    .retire_cnt(a_retire), .drop_cnt(a_drop), .overflow(a_ovf), .halted(a_halted),
    .timeout(a_timeout));

  cpu_trace_monitor #(.XLEN(64), .DEPTH(16), .HALT_INSN(32'h0), .WDOG_CYCLES(20)) dut_w (
    .clk(clk), .reset_n(reset_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_insn(retire_insn), .retire_rd_we(retire_rd_we), .retire_rd(retire_rd),
    .retire_rd_data(retire_rd_data), .retire_mem_we(retire_mem_we),
    .retire_mem_addr(retire_mem_addr), .retire_mem_data(retire_mem_data),
    .retire_br_taken(retire_br_taken), .clear(clear), .trace_valid(w_valid),
    .trace_ready(trace_ready), .trace_entry(w_entry), .cycle_cnt(w_cycle),
    .retire_cnt(w_retire), .drop_cnt(w_drop), .overflow(w_ovf), .halted(w_halted),
    .timeout(w_timeout));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of dut_a: a queue of pending entries plus run/stop bookkeeping.
  trace_entry_t mq[$];
  int           m_phase;      // 0 running, 1 stopped and draining, 2 finished
  logic [63:0]  m_cycle, m_retire;
  int           m_drop;
  bit           m_ovf, m_halt_cause, m_halted;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_entry(input string name, input trace_entry_t act, input trace_entry_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic trace_entry_t cur_entry();
    trace_entry_t e;
    e = '0;
    e.pc       = retire_pc;
    e.insn     = retire_insn;
    e.rd_we    = retire_rd_we;
    e.rd       = retire_rd;
    e.rd_data  = retire_rd_data;
    e.br_taken = retire_br_taken;
`ifdef TRACE_MEM_EN
    e.mem_we   = retire_mem_we;
    e.mem_addr = retire_mem_addr;
    e.mem_data = retire_mem_data;
`endif
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_cycle = 0; m_retire = 0; m_drop = 0;
    m_ovf = 0; m_halt_cause = 0; m_halted = 0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    bit pop;
    bit push_new;
    push_new = 0;
    if (clear) begin
      model_reset();
      return;
    end
    pop = (mq.size() != 0) && trace_ready;
    if (m_phase == 0) begin
      m_cycle++;
      if (retire_valid && retire_insn != 32'h0) begin
        m_retire++;
        if (mq.size() < A_DEPTH || pop) push_new = 1;
        else begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1;
        end
      end
      if (retire_valid && retire_insn == 32'h0) begin
        m_phase = 1;
        m_halt_cause = 1;
      end
    end else if (m_phase == 1) begin
      if (mq.size() == 0) begin
        m_phase = 2;
        m_halted = m_halt_cause;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push_new) mq.push_back(cur_entry());
  endtask

  task automatic compare_model();
    check64("trace_valid", 64'(a_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) check_entry("trace_entry", a_entry, mq[0]);
    check64("cycle_cnt", a_cycle, m_cycle);
    check64("retire_cnt", a_retire, m_retire);
    check64("drop_cnt", 64'(a_drop), 64'(m_drop));
    check64("overflow", 64'(a_ovf), 64'(m_ovf));
    check64("halted", 64'(a_halted), 64'(m_halted));
    check64("timeout", 64'(a_timeout), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    compare_model();
  endtask

  task automatic drive_retire(input logic [63:0] pc, input logic [31:0] insn);
    retire_valid    = 1'b1;
    retire_pc       = pc;
    retire_insn     = insn;
    retire_rd_we    = (insn[11:7] != 5'd0);
    retire_rd       = insn[11:7];
    retire_rd_data  = pc ^ 64'h5A5A_0000_1234_0000;
    retire_mem_we   = (insn[6:0] == 7'h23);
    retire_mem_addr = pc + 64'h1000;
    retire_mem_data = ~pc;
    retire_br_taken = (insn[6:0] == 7'h63);
  endtask

  task automatic drive_idle();
    retire_valid = 1'b0;
  endtask

  task automatic check_all_reset(input string tag);
    trace_entry_t zero_e;
    zero_e = '0;
    check64({tag, "_valid"}, 64'(a_valid), 64'd0);
    check_entry({tag, "_entry"}, a_entry, zero_e);
    check64({tag, "_cycle"}, a_cycle, 64'd0);
    check64({tag, "_retire"}, a_retire, 64'd0);
    check64({tag, "_drop"}, 64'(a_drop), 64'd0);
    check64({tag, "_flags"}, 64'({a_ovf, a_halted, a_timeout}), 64'd0);
    check64({tag, "_w_cycle"}, w_cycle, 64'd0);
    check64({tag, "_w_timeout"}, 64'(w_timeout), 64'd0);
  endtask

  typedef struct {
    bit          rv;
    logic [63:0] pc;
    logic [31:0] insn;
    bit          e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_retire;
    bit          e_halted;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [63:0] exp_pcs[3];

    tbl[0] = '{1, 64'h00, ADDI, 1, 64'h00, 64'd1, 0};
    tbl[1] = '{1, 64'h04, ADDI, 1, 64'h04, 64'd2, 0};
    tbl[2] = '{1, 64'h08, ADDI, 1, 64'h08, 64'd3, 0};
    tbl[3] = '{1, 64'h0C, ADDI, 1, 64'h0C, 64'd4, 0};
    tbl[4] = '{1, 64'h10, ADDI, 1, 64'h10, 64'd5, 0};
    tbl[5] = '{1, 64'h14, 32'h0, 0, 64'h00, 64'd5, 0};
    tbl[6] = '{0, 64'h00, ADDI, 0, 64'h00, 64'd5, 1};
    tbl[7] = '{0, 64'h00, ADDI, 0, 64'h00, 64'd5, 1};

    reset_n = 1'b1; clear = 1'b0; trace_ready = 1'b0;
    retire_valid = 0; retire_pc = 0; retire_insn = ADDI; retire_rd_we = 0; retire_rd = 0;
    retire_rd_data = 0; retire_mem_we = 0; retire_mem_addr = 0; retire_mem_data = 0;
    retire_br_taken = 0;
    #1 reset_n = 1'b0;
    #1 check_all_reset("reset");
    model_reset();
    @(negedge clk) reset_n = 1'b1;

    // Five addi then the halt word, consumer always ready.
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rv) drive_retire(tbl[i].pc, tbl[i].insn);
      else drive_idle();
      step();
      check64($sformatf("prog%0d_valid", i), 64'(a_valid), 64'(tbl[i].e_valid));
      if (tbl[i].e_valid) check64($sformatf("prog%0d_pc", i), a_entry.pc, tbl[i].e_pc);
      check64($sformatf("prog%0d_retire", i), a_retire, tbl[i].e_retire);
      check64($sformatf("prog%0d_halted", i), 64'(a_halted), 64'(tbl[i].e_halted));
    end
    check64("prog_timeout", 64'(a_timeout), 64'd0);

    // Clear while finished: halted drops right after the clear edge.
    clear = 1'b1; step(); clear = 1'b0;
    check64("clr_halted", 64'(a_halted), 64'd0);
    check64("clr_retire", a_retire, 64'd0);

    // Overflow: six retires with consumer stalled into a 4-deep FIFO.
    trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_retire(64'(i * 4), ADDI);
      step();
    end
    check64("ovf_drop", 64'(a_drop), 64'd2);
    check64("ovf_flag", 64'(a_ovf), 64'd1);
    check64("ovf_head", a_entry.pc, 64'h0);

    // Full FIFO, push and pop together: accepted, head advances by one.
    trace_ready = 1'b1;
    drive_retire(64'h18, ADDI);
    step();
    check64("fullpp_drop", 64'(a_drop), 64'd2);
    check64("fullpp_head", a_entry.pc, 64'h4);
    drive_idle();
    exp_pcs[0] = 64'h8; exp_pcs[1] = 64'hC; exp_pcs[2] = 64'h18;
    for (int i = 0; i < 3; i++) begin
      step();
      check64($sformatf("drain%0d_pc", i), a_entry.pc, exp_pcs[i]);
    end
    step();
    check64("drain_empty", 64'(a_valid), 64'd0);

    // Watchdog on dut_w: infinite beq loop.
    clear = 1'b1; step(); clear = 1'b0;
    drive_retire(64'h40, BEQ0);
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 19) check64("wdog_early", 64'(w_timeout), 64'd0);
      if (i == 20) begin
        check64("wdog_fire", 64'(w_timeout), 64'd1);
        check64("wdog_head_valid", 64'(w_valid), 64'd1);
        check64("wdog_head_pc", w_entry.pc, 64'h40);
      end
    end
    check64("wdog_cycle", w_cycle, 64'd20);
    check64("wdog_retire", w_retire, 64'd20);
    check64("wdog_halted", 64'(w_halted), 64'd0);
    check64("wdog_drained", 64'(w_valid), 64'd0);
    check64("wdog_noovf", 64'({w_ovf, 16'(w_drop)}), 64'd0);

    // Asynchronous reset with three entries queued.
    clear = 1'b1; step(); clear = 1'b0;
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_retire(64'h100 + 64'(i * 4), ADDI);
      step();
    end
    drive_idle();
    #2 reset_n = 1'b0;
    #1 check_all_reset("midrst");
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    drive_retire(64'h80, ADDI);
    step();
    check64("postrst_pc", a_entry.pc, 64'h80);
    check64("postrst_retire", a_retire, 64'd1);

    // Halt, clear in DONE, rerun.
    trace_ready = 1'b1;
    drive_retire(64'h84, 32'h0); step();
    drive_idle(); step(); step(); step();
    check64("done_halted", 64'(a_halted), 64'd1);
    clear = 1'b1; step(); clear = 1'b0;
    check64("rerun_clr_halted", 64'(a_halted), 64'd0);
    check64("rerun_clr_cycle", a_cycle, 64'd0);
    drive_retire(64'h0, SD); step();
    check64("rerun_retire", a_retire, 64'd1);
`ifdef TRACE_MEM_EN
    check64("sd_mem_we", 64'(a_entry.mem_we), 64'd1);
    check64("sd_mem_addr", a_entry.mem_addr, 64'h1000);
    check64("sd_mem_data", a_entry.mem_data, ~64'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      clear = ($urandom_range(0, 39) == 0);
      trace_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 7) begin
        drive_retire({$urandom, $urandom},
                     ($urandom_range(0, 29) == 0) ? 32'h0 : $urandom);
        retire_rd_data  = {$urandom, $urandom};
        retire_mem_data = {$urandom, $urandom};
      end else drive_idle();
      step();
    end
    clear = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
